alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
- Downstream stage of the ALU: captures each registered result word (o_alu_out qualified by o_out_valid) into a small FIFO.
- Emits each word as BYTES consecutive bytes on a valid/ready byte stream toward the UART TX framer.
- The ALU has no backpressure, so this block absorbs bursts and reports any words it must drop.

Parameters:
- IN_WIDTH, 16, result word width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, output byte width.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- MSB_FIRST, 0, 0 sends the least-significant byte first, 1 sends the most-significant byte first.
- Derived localparam BYTES = IN_WIDTH/BYTE_WIDTH.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_alu_out  in  IN_WIDTH  result word from the ALU.
- i_out_valid  in  1  result qualifier; one word per high cycle.
- o_byte  out  BYTE_WIDTH  current output byte.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  consumer accepts o_byte this cycle.
- o_fifo_count  out  clog2(DEPTH)+1  words currently stored.
- o_overflow  out  1  one-cycle pulse when an input word is dropped.
- o_drop_cnt  out  8  count of dropped words; saturates at 255.
- o_busy  out  1  high when the FIFO is non-empty or the FSM is in SEND.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - FIFO pointers and count are cleared and the FSM goes to IDLE; the byte index is cleared.
  - o_byte_valid=0, o_overflow=0, o_drop_cnt=0, o_fifo_count=0, o_busy=0.
  - o_byte is 0 while the FIFO is empty.
  - A partially sent word is abandoned; no bytes of it are resent after reset.
  - FIFO storage contents are not reset.
- Write:
  - A word is stored at the edge where i_out_valid=1 and there is space.
  - Space exists when count<DEPTH, or when count==DEPTH and the head word's last byte hands off in the same cycle (simultaneous pop frees the slot).
  - Otherwise the word is dropped: o_overflow pulses for one cycle after that edge and o_drop_cnt increments (saturating).
- Transfer: a handshake occurs when o_byte_valid && i_byte_ready at the rising edge.
- FSM with states IDLE and SEND:
  - IDLE: o_byte_valid=0. Go to SEND when count!=0, with byte index=0.
  - SEND: o_byte_valid=1. o_byte = slice of the head word selected by the byte index:
    - MSB_FIRST=0: index 0 is bits [BYTE_WIDTH-1:0].
    - MSB_FIRST=1: index 0 is the top slice.
  - On a handshake with index<BYTES-1: the index increments.
  - On a handshake with index==BYTES-1:
    - The head word is popped and the index returns to 0.
    - Stay in SEND if the post-update count (including a same-cycle write) is non-zero; otherwise go to IDLE.
- Latency: a word sampled at edge k gives o_byte_valid=1 after edge k+1 if the FSM was IDLE. This is a fixed 2-edge latency from ALU valid to first byte.
- Stability: while o_byte_valid=1 and i_byte_ready=0, o_byte and o_byte_valid must hold unchanged.
- Back-to-back words with continuous ready: no idle cycle between the last byte of one word and the first byte of the next.
- Simultaneous write and pop: count is unchanged and the pointers advance together.
- Pointers wrap modulo DEPTH. Full/empty are derived from count, not from pointer equality alone.
- o_fifo_count is registered and reflects the state after each edge.

Decomposition:
- Shared package alu_ser_pkg holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_SEND=1'b1).
  - A clog2 function.
  - A default BYTE_WIDTH constant, shared with the UART TX block.
- One sub-module, alu_res_fifo: synchronous FIFO (width IN_WIDTH, DEPTH) with push, pop, full, empty, count, and a combinational head-word read.
- The top level holds the FSM, byte index, byte mux and overflow logic.

Test Plan:
- Reset then single word, ready tied 1: i_alu_out=16'hA55A for one cycle → after 2 edges o_byte=8'h5A, next cycle 8'hA5, then o_byte_valid=0 and o_busy=0.
- MSB_FIRST=1, word 16'h1234, ready 1 → bytes 8'h12 then 8'h34.
- Backpressure: word 16'hBEEF with ready=0 for 5 cycles → o_byte holds 8'hEF and valid stays 1; ready=1 → 8'hEF then 8'hBE.
- Overflow: ready=0, 6 consecutive valid words 16'h0001..16'h0006 → first 4 stored (count=4); words 5 and 6 dropped; two o_overflow pulses; o_drop_cnt=2. Ready=1 → bytes 01,00,02,00,03,00,04,00.
- Full plus simultaneous pop: count=4, ready=1, last byte of head handing off while a new valid word 16'h00FF arrives → word accepted, count stays 4, no overflow pulse.
- Reset mid-word: after the first byte of 16'hCAFE hands off, assert i_rst for 1 cycle → o_byte_valid=0 immediately (asynchronous), count=0; no 8'hCA ever emitted; the next word sends normally.

Source files
------------

// File: rtl/alu_ser_pkg.sv
// Shared definitions for the ALU result serializer and its neighbours:
// FSM state encoding, a ceiling-log2 helper and the default byte width
// also used by the UART TX framer.
package alu_ser_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEND = 1'b1;

   localparam int DEFAULT_BYTE_WIDTH = 8;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      int p;
      r = 0;
      p = 32'sd1;
      while (p < value) begin
         p = p * 32'sd2;
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous word FIFO. Full/empty come from the occupancy count, so the
// pointers may be equal in both states. The caller only pushes when there
// is room (or a pop happens in the same cycle) and only pops when non-empty.
module alu_res_fifo
   import alu_ser_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [clog2(DEPTH):0]  o_count
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Word storage; contents intentionally survive reset.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         mem_r[wr_ptr_r] <= i_wdata;
      end
   end

   // Pointers wrap naturally (power-of-two depth); count tracks push/pop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (i_push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (i_pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign o_head  = mem_r[rd_ptr_r];
   assign o_full  = (count_r == CNT_W'(DEPTH));
   assign o_empty = (count_r == CNT_W'(0));
   assign o_count = count_r;

endmodule

// File: rtl/alu_result_serializer.sv
// Captures ALU result words into a small FIFO and streams each one out as
// BYTES bytes on a valid/ready interface. The ALU cannot be stalled, so a
// word arriving with no room is dropped and reported.
module alu_result_serializer
   import alu_ser_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
   parameter int DEPTH      = 4,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [IN_WIDTH-1:0]    i_alu_out,
   input  logic                   i_out_valid,
   output logic [BYTE_WIDTH-1:0]  o_byte,
   output logic                   o_byte_valid,
   input  logic                   i_byte_ready,
   output logic [clog2(DEPTH):0]  o_fifo_count,
   output logic                   o_overflow,
   output logic [7:0]             o_drop_cnt,
   output logic                   o_busy
);

   localparam int BYTES = IN_WIDTH / BYTE_WIDTH;
   localparam int IDX_W = (BYTES > 1) ? clog2(BYTES) : 1;
   localparam int CNT_W = clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic                  state_r;
   logic                  state_next_s;
   logic [IDX_W-1:0]      idx_r;
   logic [IDX_W-1:0]      idx_next_s;
   logic [IDX_W-1:0]      sel_s;
   logic [IN_WIDTH-1:0]   head_s;
   logic                  full_s;
   logic                  empty_s;
   logic [CNT_W-1:0]      count_s;
   logic [CNT_W-1:0]      cnt_next_s;
   logic                  hs_s;
   logic                  last_hs_s;
   logic                  push_s;
   logic                  drop_s;
   logic                  overflow_r;
   logic [7:0]            drop_cnt_r;
   logic                  busy_r;
   logic [BYTE_WIDTH-1:0] slices_s [BYTES];

   alu_res_fifo #(
      .WIDTH (IN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push_s),
      .i_wdata (i_alu_out),
      .i_pop   (last_hs_s),
      .o_head  (head_s),
      .o_full  (full_s),
      .o_empty (empty_s),
      .o_count (count_s)
   );

   // A handshake on the final byte pops the head, which frees a slot for
   // a word arriving in that same cycle even when the FIFO is full.
   assign hs_s       = (state_r == ST_SEND) && i_byte_ready;
   assign last_hs_s  = hs_s && (idx_r == LAST_IDX);
   assign push_s     = i_out_valid && (!full_s || last_hs_s);
   assign drop_s     = i_out_valid && full_s && !last_hs_s;
   assign cnt_next_s = count_s + CNT_W'(push_s) - CNT_W'(last_hs_s);

   for (genvar g = 0; g < BYTES; g++) begin : g_slice
      assign slices_s[g] = head_s[g*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // Map the transmit index onto a head-word slice according to byte order.
   always_comb begin
      if (MSB_FIRST) begin
         sel_s = LAST_IDX - idx_r;
      end else begin
         sel_s = idx_r;
      end
   end

   // Byte mux; forced to zero while nothing is stored.
   always_comb begin
      if (empty_s) begin
         o_byte = BYTE_WIDTH'(0);
      end else begin
         o_byte = slices_s[sel_s];
      end
   end

   // Next-state logic: IDLE waits for data, SEND walks the byte index.
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            idx_next_s = IDX_W'(0);
            if (count_s != CNT_W'(0)) begin
               state_next_s = ST_SEND;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_hs_s) begin
               idx_next_s = IDX_W'(0);
               if (cnt_next_s != CNT_W'(0)) begin
                  state_next_s = ST_SEND;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else if (hs_s) begin
               idx_next_s = idx_r + IDX_W'(1);
            end else begin
               idx_next_s = idx_r;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            idx_next_s   = IDX_W'(0);
         end
      endcase
   end

   // FSM and byte index registers; reset abandons any partial word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         idx_r   <= IDX_W'(0);
      end else begin
         state_r <= state_next_s;
         idx_r   <= idx_next_s;
      end
   end

   // Drop reporting and registered busy flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         busy_r     <= 1'b0;
      end else begin
         overflow_r <= drop_s;
         if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end
         busy_r <= (cnt_next_s != CNT_W'(0)) || (state_next_s == ST_SEND);
      end
   end

   assign o_byte_valid = (state_r == ST_SEND);
   assign o_fifo_count = count_s;
   assign o_overflow   = overflow_r;
   assign o_drop_cnt   = drop_cnt_r;
   assign o_busy       = busy_r;

endmodule
